// File: rtl/operand_stager.sv
// Operand staging front-end: buffers operand sets in a FIFO, drives them one at a
// time into a combinational compute stage, and registers the settled result.
module operand_stager #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_sel,
    output logic [WIDTH-1:0]           data_a,
    output logic [WIDTH-1:0]           data_b,
    output logic                       select,
    input  logic [WIDTH-1:0]           result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_sel,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t              state, next_state;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [2*WIDTH:0]    mem [DEPTH];
    logic [3:0]          cnt;
    logic                push, pop, capture, release_out;

    assign in_ready = (level != FULL);
    assign push     = in_valid && in_ready;

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (level != '0) begin
                    pop        = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    release_out = 1'b1;
                    if (level != '0) begin
                        pop        = 1'b1;
                        next_state = WAIT;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and level alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_sel, in_a, in_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Drive registers move only on a pop, keeping the compute stage quiet through WAIT and HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a <= '0;
            data_b <= '0;
            select <= 1'b0;
            cnt    <= '0;
        end else if (pop) begin
            {select, data_a, data_b} <= mem[rd_ptr];
            cnt                      <= 4'(SETTLE);
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_sel    <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            out_result <= result;
            out_sel    <= select;
        end else if (release_out) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_stager.sv
// Scoreboard bench for operand_stager: one SETTLE=1 instance for the main flows and
// a SETTLE=3 instance for the long-settle timing.
module tb_operand_stager;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sel;
        logic [3:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       u1_in_valid, u1_in_ready, u1_in_sel, u1_select, u1_out_valid, u1_out_ready, u1_out_sel, u1_busy;
    logic [3:0] u1_in_a, u1_in_b, u1_data_a, u1_data_b, u1_result, u1_out_result;
    logic [2:0] u1_level;
    logic       u3_in_valid, u3_in_ready, u3_in_sel, u3_select, u3_out_valid, u3_out_ready, u3_out_sel, u3_busy;
    logic [3:0] u3_in_a, u3_in_b, u3_data_a, u3_data_b, u3_result, u3_out_result;
    logic [2:0] u3_level;

    // Stand-in compute stage: a 2:1 mux.
    assign u1_result = u1_select ? u1_data_b : u1_data_a;
    assign u3_result = u3_select ? u3_data_b : u3_data_a;

    operand_stager #(.WIDTH(4), .DEPTH(4), .SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
        .in_a(u1_in_a), .in_b(u1_in_b), .in_sel(u1_in_sel),
        .data_a(u1_data_a), .data_b(u1_data_b), .select(u1_select), .result(u1_result),
        .out_valid(u1_out_valid), .out_ready(u1_out_ready), .out_result(u1_out_result),
        .out_sel(u1_out_sel), .level(u1_level), .busy(u1_busy));

    operand_stager #(.WIDTH(4), .DEPTH(4), .SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(u3_in_valid), .in_ready(u3_in_ready),
        .in_a(u3_in_a), .in_b(u3_in_b), .in_sel(u3_in_sel),
        .data_a(u3_data_a), .data_b(u3_data_b), .select(u3_select), .result(u3_result),
        .out_valid(u3_out_valid), .out_ready(u3_out_ready), .out_result(u3_out_result),
        .out_sel(u3_out_sel), .level(u3_level), .busy(u3_busy));

    int         checks   = 0;
    int         failures = 0;
    int         cycle    = 0;
    int         last_hs  = -1;
    bit         stream_mode = 1'b0;
    logic [4:0] sb [$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: every completed output handshake is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && u1_out_valid && u1_out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h with sel %0b, expected no result", u1_out_result, u1_out_sel);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                check("out_result", {28'd0, u1_out_result}, {28'd0, e[3:0]});
                check("out_sel", {31'd0, u1_out_sel}, {31'd0, e[4]});
            end
            if (stream_mode) begin
                if (last_hs >= 0) check("stream_gap", cycle - last_hs, 2);
                last_hs = cycle;
            end
        end
    end

    // Offers one set for one cycle; starts and ends just after a rising edge.
    task automatic try_push(input vec_t v, output bit acc);
        u1_in_a     = v.a;
        u1_in_b     = v.b;
        u1_in_sel   = v.sel;
        u1_in_valid = 1'b1;
        @(negedge clk);
        acc = u1_in_ready;
        if (acc) sb.push_back({v.sel, v.exp});
        @(posedge clk);
        #1 u1_in_valid = 1'b0;
    endtask

    task automatic push_wait(input vec_t v);
        bit acc = 1'b0;
        int t = 0;
        while (!acc && t < 40) begin
            try_push(v, acc);
            t++;
        end
        check("push_timeout", {31'd0, acc}, 1);
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((sb.size() != 0 || u1_out_valid) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_in_time", {31'd0, n < max}, 1);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    vec_t single = '{4'h3, 4'hA, 1'b1, 4'hA};
    vec_t fill [6] = '{'{4'h1, 4'h2, 1'b0, 4'h1}, '{4'h4, 4'h7, 1'b1, 4'h7},
                       '{4'h8, 4'h6, 1'b0, 4'h8}, '{4'hC, 4'hD, 1'b1, 4'hD},
                       '{4'hE, 4'h5, 1'b0, 4'hE}, '{4'hF, 4'h0, 1'b1, 4'h0}};
    vec_t strm [8] = '{'{4'h1, 4'hF, 1'b0, 4'h1}, '{4'h2, 4'hE, 1'b1, 4'hE},
                       '{4'h3, 4'hD, 1'b0, 4'h3}, '{4'h4, 4'hC, 1'b1, 4'hC},
                       '{4'h5, 4'hB, 1'b0, 4'h5}, '{4'h6, 4'hA, 1'b1, 4'hA},
                       '{4'h7, 4'h9, 1'b0, 4'h7}, '{4'h8, 4'h8, 1'b1, 4'h8}};
    vec_t rst_v [4] = '{'{4'h1, 4'h2, 1'b0, 4'h1}, '{4'h3, 4'h4, 1'b1, 4'h4},
                        '{4'h5, 4'h6, 1'b0, 4'h5}, '{4'h7, 4'h8, 1'b1, 4'h8}};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int nacc;
        rst_n = 1'b0;
        u1_in_valid = 1'b0; u1_in_a = '0; u1_in_b = '0; u1_in_sel = 1'b0; u1_out_ready = 1'b0;
        u3_in_valid = 1'b0; u3_in_a = '0; u3_in_b = '0; u3_in_sel = 1'b0; u3_out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_level", {29'd0, u1_level}, 0);
        check("rst_in_ready", {31'd0, u1_in_ready}, 1);
        check("rst_out_valid", {31'd0, u1_out_valid}, 0);
        check("rst_busy", {31'd0, u1_busy}, 0);
        check("rst_drive", {23'd0, u1_data_a, u1_data_b, u1_select}, 0);
        check("rst_out", {27'd0, u1_out_result, u1_out_sel}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single transaction
        try_push(single, acc);
        check("single_acc", {31'd0, acc}, 1);
        check("single_e0_level", {29'd0, u1_level}, 1);
        check("single_e0_busy", {31'd0, u1_busy}, 0);
        tick();
        check("single_e1_data_a", {28'd0, u1_data_a}, 32'h3);
        check("single_e1_data_b", {28'd0, u1_data_b}, 32'hA);
        check("single_e1_select", {31'd0, u1_select}, 1);
        check("single_e1_busy", {31'd0, u1_busy}, 1);
        check("single_e1_valid", {31'd0, u1_out_valid}, 0);
        tick();
        check("single_e2_valid", {31'd0, u1_out_valid}, 1);
        check("single_e2_result", {28'd0, u1_out_result}, 32'hA);
        check("single_e2_sel", {31'd0, u1_out_sel}, 1);
        check("single_e2_busy", {31'd0, u1_busy}, 1);
        u1_out_ready = 1'b1;
        tick();
        check("single_e3_valid", {31'd0, u1_out_valid}, 0);
        check("single_e3_busy", {31'd0, u1_busy}, 0);
        u1_out_ready = 1'b0;

        // Fill and stall, then push against a full FIFO during the HOLD handshake
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            try_push(fill[i], acc);
            nacc += int'(acc);
        end
        check("fill_accepted", nacc, 5);
        check("fill_level", {29'd0, u1_level}, 4);
        check("fill_in_ready", {31'd0, u1_in_ready}, 0);
        check("fill_valid", {31'd0, u1_out_valid}, 1);
        repeat (3) tick();
        check("stall_result", {28'd0, u1_out_result}, 32'h1);
        check("stall_level", {29'd0, u1_level}, 4);
        u1_out_ready = 1'b1;
        try_push(fill[5], acc);
        check("full_pop_push_acc", {31'd0, acc}, 0);
        check("full_pop_level", {29'd0, u1_level}, 3);
        check("full_pop_in_ready", {31'd0, u1_in_ready}, 1);
        wait_drain(100);

        // Streaming
        last_hs = -1;
        stream_mode = 1'b1;
        for (int i = 0; i < 8; i++) push_wait(strm[i]);
        wait_drain(100);
        stream_mode = 1'b0;
        u1_out_ready = 1'b0;

        // Long settle on the SETTLE=3 instance
        u3_in_a = 4'h5; u3_in_b = 4'h9; u3_in_sel = 1'b0; u3_in_valid = 1'b1;
        tick();
        u3_in_valid = 1'b0;
        check("long_e0_level", {29'd0, u3_level}, 1);
        tick();
        check("long_e1_drive", {23'd0, u3_data_a, u3_data_b, u3_select}, {23'd0, 4'h5, 4'h9, 1'b0});
        check("long_e1_busy", {31'd0, u3_busy}, 1);
        for (int e = 2; e <= 3; e++) begin
            tick();
            check("long_wait_valid", {31'd0, u3_out_valid}, 0);
            check("long_wait_drive", {23'd0, u3_data_a, u3_data_b, u3_select}, {23'd0, 4'h5, 4'h9, 1'b0});
        end
        tick();
        check("long_e4_valid", {31'd0, u3_out_valid}, 1);
        check("long_e4_result", {27'd0, u3_out_result, u3_out_sel}, {27'd0, 4'h5, 1'b0});
        check("long_e4_drive", {23'd0, u3_data_a, u3_data_b, u3_select}, {23'd0, 4'h5, 4'h9, 1'b0});
        u3_out_ready = 1'b1;
        tick();
        check("long_e5_valid", {31'd0, u3_out_valid}, 0);
        check("long_e5_busy", {31'd0, u3_busy}, 0);
        u3_out_ready = 1'b0;

        // Reset mid-operation: reach WAIT with two entries queued
        for (int i = 0; i < 3; i++) try_push(rst_v[i], acc);
        u1_out_ready = 1'b1;
        try_push(rst_v[3], acc);
        u1_out_ready = 1'b0;
        check("pre_rst_level", {29'd0, u1_level}, 2);
        check("pre_rst_busy", {31'd0, u1_busy}, 1);
        check("pre_rst_valid", {31'd0, u1_out_valid}, 0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_valid", {31'd0, u1_out_valid}, 0);
        check("mid_rst_level", {29'd0, u1_level}, 0);
        check("mid_rst_drive", {23'd0, u1_data_a, u1_data_b, u1_select}, 0);
        check("mid_rst_busy", {31'd0, u1_busy}, 0);
        @(negedge clk) rst_n = 1'b1;
        u1_out_ready = 1'b1;
        repeat (6) tick();
        check("post_rst_valid", {31'd0, u1_out_valid}, 0);
        check("post_rst_in_ready", {31'd0, u1_in_ready}, 1);
        check("post_rst_level", {29'd0, u1_level}, 0);
        check("post_rst_busy", {31'd0, u1_busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_stager.md
# operand_stager

Sequential front-end that buffers operand pairs in a small FIFO, issues them one at a time to the combinational mux/ALU compute stage, and registers that stage's result. It sits directly upstream of the compute stage: it drives that stage's `data_a`, `data_b` and `select` inputs and samples its `result`. Upstream producers and downstream consumers see independent valid/ready handshakes.

## Interface
- `WIDTH`, default 4: operand and result width in bits.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, ≥2.
- `SETTLE`, default 1: compute-stage settle time in cycles, from the drive-register update to the result capture. Legal range is 1–15.

Ports:
- `clk`  in  1  sole clock. Everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream offers an operand set.
- `in_ready`  out  1  FIFO can accept an entry.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_sel`  in  1  select/opcode bit for the compute stage.
- `data_a`, `data_b`  out  WIDTH  registered operands driven to the compute stage.
- `select`  out  1  registered select driven to the compute stage.
- `result`  in  WIDTH  compute-stage output. Treated as combinational in `data_a`/`data_b`/`select`.
- `out_valid`  out  1  captured result is available.
- `out_ready`  in  1  downstream accepts the result.
- `out_result`  out  WIDTH  captured result.
- `out_sel`  out  1  `select` value that produced `out_result`.
- `level`  out  clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- **FIFO:** circular buffer with read/write pointers and an occupancy counter.
  - Push when `in_valid && in_ready`.
  - `in_ready = (level != DEPTH)`, derived from the registered level. A push is never accepted while full, even if a pop occurs in the same cycle.
  - Pop only from IDLE or HOLD (see FSM), and only when the registered `level > 0`. There is no empty bypass.
  - A simultaneous push and pop leaves `level` unchanged. Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, WAIT, HOLD.
  - **IDLE:** if `level > 0`, pop the head into `data_a`/`data_b`/`select`, load the counter with SETTLE, and go to WAIT. Otherwise stay, with the drive registers holding their last values.
  - **WAIT:** decrement the counter each cycle. In the cycle where the counter equals 1, capture `result` into `out_result` and `select` into `out_sel`, set `out_valid`, and go to HOLD.
  - **HOLD:** `out_valid` = 1, and `out_result`/`out_sel` are stable.
    - On `out_valid && out_ready` with `level > 0`: pop the next entry at the same edge, go to WAIT, and clear `out_valid`.
    - On handshake with `level == 0`: go to IDLE and clear `out_valid`.
    - Without handshake: stay in HOLD.
- Drive registers change only on a pop. The compute stage therefore sees stable inputs throughout WAIT and HOLD.
- No arithmetic is performed here. `result` is captured bit-for-bit at WIDTH bits.

## Timing
- **Reset** (asynchronous assert, synchronous release on the first `clk` edge after deassertion):
  - state IDLE; pointers 0; `level` 0;
  - `data_a`, `data_b`, `select`, `out_result`, `out_sel` all 0;
  - `out_valid` 0; `busy` 0;
  - `in_ready` 1 (combinational from `level`).
- **Reset mid-operation:** discards all FIFO entries, the in-flight operand set, and any unconsumed result. No output handshake completes after reset.
- **Latency:** for an entry accepted at edge E0 into an empty, idle block:
  - popped at E1 (drive registers visible after E1);
  - captured at E(1+SETTLE);
  - `out_valid` high from then on. With SETTLE=1, `out_valid` rises 2 edges after acceptance.
- **Throughput** with `out_ready` held high: one result per SETTLE+1 cycles.
- **Back-pressure:** `out_ready` low holds HOLD indefinitely. The FIFO keeps accepting until full, then `in_ready` drops. `in_ready` rises one cycle after the pop that frees a slot.
- `level` updates at the edge of a push or pop. `busy` is registered with the state.

## Test plan
- **Single transaction** (SETTLE=1, bench models `result = sel ? b : a`): push a=4'h3, b=4'hA, sel=1 at E0 → `data_b`=4'hA at E1; `out_valid` high after E2 with `out_result`=4'hA and `out_sel`=1; `busy` high from E1 until the handshake.
- **Fill and stall:** hold `out_ready`=0 and push 6 sets → 5 accepted (1 issued plus 4 in FIFO); `in_ready`=0 with `level`=4; the first result stays stable; raising `out_ready` drains the results in order.
- **Streaming:** SETTLE=1, `out_ready`=1, push 8 consecutive sets → results appear every 2 cycles, in order, with values matching the model.
- **Long settle:** SETTLE=3 with a single push at E0 → capture at E4; `data_a`/`data_b`/`select` unchanged during E1–E4.
- **Reset mid-operation:** assert `rst_n`=0 in WAIT with `level`=2 → immediately `out_valid`=0, `level`=0, drive registers 0; after release, no stale result appears and `in_ready`=1.
- **Simultaneous push/pop at full:** with `level`=4 and the HOLD handshake occurring in the same cycle as `in_valid` → no push that cycle; `level`=3 next cycle and `in_ready`=1.
